// File: rtl/demux_pkg.sv
// Shared definitions for the 1:8 TDM link (serial mux and demux sides).
package demux_pkg;

    localparam int N_CH_DEF  = 8;
    localparam int SEL_W_DEF = 3;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SEND = 2'd1,
        ST_DONE = 2'd2
    } state_t;

endpackage

// File: rtl/tdm_chan_counter.sv
// Channel index counter: synchronous clear, enable, terminal-count flag at N_CH-1.
module tdm_chan_counter
    import demux_pkg::*;
#(
    parameter int N_CH  = N_CH_DEF,
    parameter int SEL_W = SEL_W_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic             en,
    output logic [SEL_W-1:0] cnt,
    output logic             tc
);

    localparam logic [SEL_W-1:0] LAST = SEL_W'(N_CH - 1);

    // Compare against N_CH-1 so a non-power-of-2 frame never walks past its last channel.
    assign tc = (cnt == LAST);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (clear) begin
            cnt <= '0;
        end else if (en) begin
            cnt <= tc ? '0 : cnt + 1'b1;
        end
    end

endmodule

// File: rtl/tdm_serial_mux.sv
// Transmit end of the TDM link: captures a word on start and sends one bit per cycle
// on k with its channel index on s, with start/busy/done toward the source.
module tdm_serial_mux
    import demux_pkg::*;
#(
    parameter int N_CH       = N_CH_DEF,
    parameter int SEL_W      = SEL_W_DEF,
    parameter bit CONTINUOUS = 1'b0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             en,
    input  logic [N_CH-1:0]  d,
    output logic             k,
    output logic [SEL_W-1:0] s,
    output logic             valid,
    output logic             busy,
    output logic             done
);

    state_t            state;
    logic [N_CH-1:0]   hold;
    logic [SEL_W-1:0]  cnt;
    logic [SEL_W-1:0]  next_idx;
    logic              last_ch;
    logic              accept;
    logic              cnt_en;

    // Accepting edge: start in IDLE, or the DONE cycle when frames run back-to-back.
    assign accept   = ((state == ST_IDLE) && start) || ((state == ST_DONE) && CONTINUOUS);
    assign cnt_en   = (state == ST_SEND) && en;
    assign next_idx = cnt + 1'b1;

    tdm_chan_counter #(
        .N_CH  (N_CH),
        .SEL_W (SEL_W)
    ) u_cnt (
        .clk   (clk),
        .rst   (rst),
        .clear (accept),
        .en    (cnt_en),
        .cnt   (cnt),
        .tc    (last_ch)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_IDLE;
            hold  <= '0;
            k     <= 1'b0;
            s     <= '0;
            valid <= 1'b0;
            busy  <= 1'b0;
            done  <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        hold  <= d;
                        k     <= d[0];
                        s     <= '0;
                        valid <= 1'b1;
                        busy  <= 1'b1;
                        state <= ST_SEND;
                    end
                end
                ST_SEND: begin
                    if (en) begin
                        if (!last_ch) begin
                            s <= next_idx;
                            k <= hold[next_idx];
                        end else begin
                            k     <= 1'b0;
                            s     <= '0;
                            valid <= 1'b0;
                            busy  <= 1'b0;
                            done  <= 1'b1;
                            state <= ST_DONE;
                        end
                    end
                end
                ST_DONE: begin
                    done <= 1'b0;
                    if (CONTINUOUS) begin
                        hold  <= d;
                        k     <= d[0];
                        s     <= '0;
                        valid <= 1'b1;
                        busy  <= 1'b1;
                        state <= ST_SEND;
                    end else begin
                        state <= ST_IDLE;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_tdm_serial_mux.sv
// Bench for tdm_serial_mux: directed and random frames against a frame-level model plus a demux model.
module tb_tdm_serial_mux;

    logic       clk = 1'b0;
    logic       rst;
    logic       start, en;
    logic [7:0] d;
    logic       k;
    logic [2:0] s;
    logic       valid, busy, done;

    logic       c_start, c_en;
    logic [7:0] c_d;
    logic       c_k;
    logic [2:0] c_s;
    logic       c_valid, c_busy, c_done;

    int n_tests = 0;
    int n_fail  = 0;
    int stall [8];

    always #5 clk = ~clk;

    tdm_serial_mux #(.N_CH(8), .SEL_W(3), .CONTINUOUS(1'b0)) u_dut (
        .clk(clk), .rst(rst), .start(start), .en(en), .d(d),
        .k(k), .s(s), .valid(valid), .busy(busy), .done(done)
    );

    tdm_serial_mux #(.N_CH(8), .SEL_W(3), .CONTINUOUS(1'b1)) u_cont (
        .clk(clk), .rst(rst), .start(c_start), .en(c_en), .d(c_d),
        .k(c_k), .s(c_s), .valid(c_valid), .busy(c_busy), .done(c_done)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, " k"}, 32'(k), 32'd0);
        chk({tag, " s"}, 32'(s), 32'd0);
        chk({tag, " valid"}, 32'(valid), 32'd0);
        chk({tag, " busy"}, 32'(busy), 32'd0);
        chk({tag, " done"}, 32'(done), 32'd0);
    endtask

    // Expected frame: channel ch shown stall[ch]+1 cycles, then one done cycle, then idle.
    task automatic frame(input string tag, input logic [7:0] w, input logic [7:0] d_after,
                         input int poke_ch, input logic [7:0] poke_d, input bit lose_start);
        logic [7:0] y;
        int vcnt;
        int exp_v;
        y     = ~w;
        vcnt  = 0;
        exp_v = 8;
        d     = w;
        start = 1'b1;
        en    = 1'($urandom_range(0, 1));
        tick();
        start = 1'b0;
        d     = d_after;
        for (int ch = 0; ch < 8; ch++) begin
            exp_v += stall[ch];
            for (int rep = 0; rep <= stall[ch]; rep++) begin
                chk($sformatf("%s k ch%0d", tag, ch), 32'(k), 32'(w[ch]));
                chk($sformatf("%s s ch%0d", tag, ch), 32'(s), 32'(ch));
                chk($sformatf("%s valid ch%0d", tag, ch), 32'(valid), 32'd1);
                chk($sformatf("%s busy ch%0d", tag, ch), 32'(busy), 32'd1);
                chk($sformatf("%s done ch%0d", tag, ch), 32'(done), 32'd0);
                if (valid === 1'b1) begin
                    y[s] = k;
                    vcnt++;
                end
                en = (rep < stall[ch]) ? 1'b0 : 1'b1;
                if (ch == poke_ch && rep == 0) begin
                    start = 1'b1;
                    d     = poke_d;
                end else begin
                    start = 1'b0;
                    d     = d_after;
                end
                tick();
            end
        end
        start = lose_start;
        d     = $urandom;
        chk({tag, " done pulse"}, 32'(done), 32'd1);
        chk({tag, " done valid"}, 32'(valid), 32'd0);
        chk({tag, " done busy"}, 32'(busy), 32'd0);
        chk({tag, " done k"}, 32'(k), 32'd0);
        chk({tag, " done s"}, 32'(s), 32'd0);
        chk({tag, " demux y"}, 32'(y), 32'(w));
        chk({tag, " valid cycles"}, 32'(vcnt), 32'(exp_v));
        tick();
        start = 1'b0;
        chk_idle({tag, " after"});
    endtask

    initial begin
        rst     = 1'b1;
        start   = 1'b0;
        en      = 1'b0;
        d       = 8'h00;
        c_start = 1'b0;
        c_en    = 1'b1;
        c_d     = 8'h00;
        for (int i = 0; i < 8; i++) stall[i] = 0;
        tick();
        tick();
        chk_idle("reset");
        rst = 1'b0;
        tick();
        chk_idle("post reset");

        frame("A5", 8'hA5, 8'hA5, -1, 8'h00, 1'b0);

        // Asynchronous reset in the middle of a frame, away from any clock edge.
        d     = 8'hFF;
        start = 1'b1;
        en    = 1'b1;
        tick();
        start = 1'b0;
        tick();
        tick();
        chk("midrun valid before", 32'(valid), 32'd1);
        #2;
        rst = 1'b1;
        #1;
        chk_idle("async reset");
        tick();
        rst = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick();
            chk($sformatf("no done after reset %0d", i), 32'(done), 32'd0);
            chk($sformatf("no valid after reset %0d", i), 32'(valid), 32'd0);
        end

        stall[2] = 3;
        frame("3C stall", 8'h3C, 8'h3C, -1, 8'h00, 1'b0);
        stall[2] = 0;

        frame("00 poke", 8'h00, 8'h00, 4, 8'hFF, 1'b1);
        frame("81 dchg", 8'h81, 8'h7E, -1, 8'h00, 1'b0);

        for (int f = 0; f < 20; f++) begin
            for (int i = 0; i < 8; i++)
                stall[i] = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 3)) : 0;
            frame($sformatf("rnd%0d", f), 8'($urandom), 8'($urandom),
                  int'($urandom_range(0, 8)), 8'($urandom), 1'($urandom_range(0, 1)));
            if ($urandom_range(0, 1) == 1) tick();
        end

        // Back-to-back frames: 0F then F0, with exactly one done cycle between them.
        c_d     = 8'h0F;
        c_start = 1'b1;
        tick();
        c_start = 1'b0;
        c_d     = 8'hF0;
        for (int ch = 0; ch < 8; ch++) begin
            chk($sformatf("cont0F k ch%0d", ch), 32'(c_k), 32'((ch < 4) ? 1 : 0));
            chk($sformatf("cont0F s ch%0d", ch), 32'(c_s), 32'(ch));
            chk($sformatf("cont0F valid ch%0d", ch), 32'(c_valid), 32'd1);
            tick();
        end
        chk("cont gap done", 32'(c_done), 32'd1);
        chk("cont gap valid", 32'(c_valid), 32'd0);
        chk("cont gap k", 32'(c_k), 32'd0);
        tick();
        c_d = 8'h55;
        for (int ch = 0; ch < 8; ch++) begin
            chk($sformatf("contF0 k ch%0d", ch), 32'(c_k), 32'((ch < 4) ? 0 : 1));
            chk($sformatf("contF0 s ch%0d", ch), 32'(c_s), 32'(ch));
            chk($sformatf("contF0 valid ch%0d", ch), 32'(c_valid), 32'd1);
            chk($sformatf("contF0 busy ch%0d", ch), 32'(c_busy), 32'd1);
            chk($sformatf("contF0 done ch%0d", ch), 32'(c_done), 32'd0);
            tick();
        end
        chk("cont second done", 32'(c_done), 32'd1);
        chk("cont second valid", 32'(c_valid), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
